// File: rtl/mesm6_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mesm6_alu_seq : issue/sequencing stage in front of the MESM-6 ALU        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP (`ALU_OP_WIDTH'(0))
`endif

module mesm6_alu_seq #(
  parameter int TIMEOUT = 128,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [`ALU_OP_WIDTH-1:0] req_op,
  input  logic [47:0]              req_a,
  input  logic [47:0]              req_b,
  input  logic                     req_wy,
  input  logic                     req_log,
  input  logic                     req_norm,
  input  logic                     req_round,
  output logic [`ALU_OP_WIDTH-1:0] alu_op,
  output logic [47:0]              alu_a,
  output logic [47:0]              alu_b,
  output logic                     alu_wy,
  output logic                     alu_log,
  output logic                     alu_norm,
  output logic                     alu_round,
  input  logic [47:0]              alu_acc,
  input  logic                     alu_done,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [47:0]              resp_acc,
  output logic                     resp_zero,
  output logic                     resp_neg,
  output logic                     resp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  // Logical results are whole-word; arithmetic results only look at the 41-bit mantissa field.
  function automatic logic f_zero(input logic [47:0] acc, input logic lg);
    return lg ? (acc == 48'd0) : (acc[40:0] == 41'd0);
  endfunction

  function automatic logic f_neg(input logic [47:0] acc, input logic lg);
    return lg ? 1'b0 : acc[40];
  endfunction

  assign req_ready = (r_state == S_IDLE) && !flush;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      alu_op     <= `ALU_NOP;
      alu_a      <= 48'd0;
      alu_b      <= 48'd0;
      alu_wy     <= 1'b0;
      alu_log    <= 1'b0;
      alu_norm   <= 1'b0;
      alu_round  <= 1'b0;
      resp_valid <= 1'b0;
      resp_acc   <= 48'd0;
      resp_zero  <= 1'b0;
      resp_neg   <= 1'b0;
      resp_err   <= 1'b0;
    end else if (flush) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      alu_op     <= `ALU_NOP;
      alu_wy     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      alu_wy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_log   <= req_log;
            alu_norm  <= req_norm;
            alu_round <= req_round;
            r_cnt     <= '0;
            if (req_op == `ALU_NOP) begin
              // Y-write only: pulse wy for one cycle and answer with operand A.
              alu_op     <= `ALU_NOP;
              alu_wy     <= req_wy;
              resp_acc   <= req_a;
              resp_zero  <= f_zero(req_a, req_log);
              resp_neg   <= f_neg(req_a, req_log);
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              alu_op  <= req_op;
              r_state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (alu_done) begin
            resp_acc   <= alu_acc;
            resp_zero  <= f_zero(alu_acc, alu_log);
            resp_neg   <= f_neg(alu_acc, alu_log);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            alu_op     <= `ALU_NOP;
            r_state    <= S_RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            resp_acc   <= 48'd0;
            resp_zero  <= 1'b1;
            resp_neg   <= 1'b0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            alu_op     <= `ALU_NOP;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
